// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX paths:
// the transmit FSM state encoding and the baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Clock cycles per bit, rounded down.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..DIV-1 and flags the last cycle of each bit.
// A synchronous clear holds it at zero while the line is idle, so the first
// bit of a frame always starts from a fresh count.
module uart_baud_cnt #(
  parameter int DIV   = 16,
  parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic ckht,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running bit-period count, restarted on clear or at the end of each bit.
  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit engine. Pops one word from the TX FIFO when idle and sends it
// as start bit, DATA_SIZE data bits LSB-first, optional parity and 1 or 2 stop
// bits. The serial line is driven from a register that is loaded from the
// next-state view, so tx changes exactly when the FSM changes state.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_SIZE  = 8,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 ckht,
  input  logic                 rst,
  input  logic                 tx_empty,
  input  logic [DATA_SIZE-1:0] tx_data,
  output logic                 tx_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 done_tick
);

  localparam int   DIV   = calc_div(CLK_HZ, BAUD);
  localparam int   BIT_W = $clog2(DATA_SIZE + 1);
  localparam logic ODD   = (PARITY_ODD != 0);

  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_SIZE - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_ctrl: CLK_HZ/BAUD must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end
  if ((DATA_SIZE < 5) || (DATA_SIZE > 9)) begin : g_bad_size
    $error("uart_tx_ctrl: DATA_SIZE must be 5..9");
  end

  uart_tx_state_t state, next_state;

  logic [DATA_SIZE-1:0] shift_q, shift_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 parity_q;
  logic                 tx_nxt;
  logic                 baud_tc;
  logic                 pop;
  logic                 last_data;
  logic                 last_stop;

  assign pop       = (state == IDLE) && !tx_empty;
  assign last_data = (bit_cnt == LAST_DATA);
  assign last_stop = (bit_cnt == LAST_STOP);

  uart_baud_cnt #(
    .DIV (DIV)
  ) u_baud (
    .ckht (ckht),
    .rst  (rst),
    .clr  (state == IDLE),
    .tc   (baud_tc)
  );

  // State register; reset aborts any frame in progress.
  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame sequencing: each non-idle state lasts whole bit periods.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pop) next_state = START;
      START:   if (baud_tc) next_state = DATA;
      DATA:    if (baud_tc && last_data) next_state = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (baud_tc) next_state = STOP;
      STOP:    if (baud_tc && last_stop) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    tx_rd     = pop && !rst;
    busy      = (state != IDLE);
    done_tick = (state == STOP) && baud_tc && last_stop;
  end

  // Next values for the shift register, bit counter and serial line.
  always_comb begin
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt;
    case (state)
      IDLE: begin
        if (pop) begin
          shift_nxt   = tx_data;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (baud_tc) begin
          shift_nxt   = shift_q >> 1;
          bit_cnt_nxt = last_data ? '0 : bit_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_tc) begin
          bit_cnt_nxt = last_stop ? '0 : bit_cnt + 1'b1;
        end
      end
      default: begin
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
      end
    endcase

    tx_nxt = 1'b1;
    case (next_state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = parity_q;
      default: tx_nxt = 1'b1;
    endcase
  end

  // Datapath registers; parity is captured from the word at pop time.
  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      parity_q <= 1'b0;
      tx       <= 1'b1;
    end else begin
      shift_q <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx      <= tx_nxt;
      if (pop) begin
        parity_q <= ^tx_data ^ ODD;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with DIV=16 and 8 data bits.
// Three instances cover 8N1, 8E1 and 8N2; each is fed by a small 4-deep FIFO.
// Observed vector per cycle is {tx, busy, tx_rd, done_tick}.
module tb_uart_tx_ctrl;

  logic ckht = 1'b0;
  logic rst  = 1'b1;

  int vec_count   = 0;
  int miscompares = 0;

  always #5 ckht = ~ckht;

  // 8N1 instance with its FIFO
  logic       tx_empty_a, tx_rd_a, tx_a, busy_a, done_a;
  logic [7:0] tx_data_a;
  logic [7:0] mem_a [4];
  int unsigned wr_a = 0;
  int unsigned rd_a = 0;
  logic [3:0] obs_a;

  // 8E1 instance with its FIFO
  logic       tx_empty_b, tx_rd_b, tx_b, busy_b, done_b;
  logic [7:0] tx_data_b;
  logic [7:0] mem_b [4];
  int unsigned wr_b = 0;
  int unsigned rd_b = 0;
  logic [3:0] obs_b;

  // 8N2 instance with its FIFO
  logic       tx_empty_c, tx_rd_c, tx_c, busy_c, done_c;
  logic [7:0] tx_data_c;
  logic [7:0] mem_c [4];
  int unsigned wr_c = 0;
  int unsigned rd_c = 0;
  logic [3:0] obs_c;

  assign tx_empty_a = (wr_a == rd_a);
  assign tx_data_a  = mem_a[rd_a[1:0]];
  assign obs_a      = {tx_a, busy_a, tx_rd_a, done_a};
  assign tx_empty_b = (wr_b == rd_b);
  assign tx_data_b  = mem_b[rd_b[1:0]];
  assign obs_b      = {tx_b, busy_b, tx_rd_b, done_b};
  assign tx_empty_c = (wr_c == rd_c);
  assign tx_data_c  = mem_c[rd_c[1:0]];
  assign obs_c      = {tx_c, busy_c, tx_rd_c, done_c};

  // FIFO read side: advance on each pop strobe.
  always @(posedge ckht) begin
    if (tx_rd_a) rd_a <= rd_a + 1;
    if (tx_rd_b) rd_b <= rd_b + 1;
    if (tx_rd_c) rd_c <= rd_c + 1;
  end

  uart_tx_ctrl #(
    .DATA_SIZE (8), .CLK_HZ (16), .BAUD (1),
    .STOP_BITS (1), .PARITY_EN (0), .PARITY_ODD (0)
  ) dut_a (
    .ckht (ckht), .rst (rst), .tx_empty (tx_empty_a), .tx_data (tx_data_a),
    .tx_rd (tx_rd_a), .tx (tx_a), .busy (busy_a), .done_tick (done_a)
  );

  uart_tx_ctrl #(
    .DATA_SIZE (8), .CLK_HZ (16), .BAUD (1),
    .STOP_BITS (1), .PARITY_EN (1), .PARITY_ODD (0)
  ) dut_b (
    .ckht (ckht), .rst (rst), .tx_empty (tx_empty_b), .tx_data (tx_data_b),
    .tx_rd (tx_rd_b), .tx (tx_b), .busy (busy_b), .done_tick (done_b)
  );

  uart_tx_ctrl #(
    .DATA_SIZE (8), .CLK_HZ (16), .BAUD (1),
    .STOP_BITS (2), .PARITY_EN (0), .PARITY_ODD (0)
  ) dut_c (
    .ckht (ckht), .rst (rst), .tx_empty (tx_empty_c), .tx_data (tx_data_c),
    .tx_rd (tx_rd_c), .tx (tx_c), .busy (busy_c), .done_tick (done_c)
  );

  task automatic push_a(input logic [7:0] d);
    mem_a[wr_a[1:0]] = d;
    wr_a = wr_a + 1;
  endtask

  task automatic push_b(input logic [7:0] d);
    mem_b[wr_b[1:0]] = d;
    wr_b = wr_b + 1;
  endtask

  task automatic push_c(input logic [7:0] d);
    mem_c[wr_c[1:0]] = d;
    wr_c = wr_c + 1;
  endtask

  // Expected {tx,busy,tx_rd,done} for cycle k (1-based) after the pop cycle.
  // bits[0] is the first bit on the line (start bit).
  function automatic logic [3:0] frame_exp(input logic [10:0] bits, input int nbits, input int k);
    int   idx;
    logic b;
    idx = (k - 1) / 16;
    b   = bits[idx];
    return {b, 1'b1, 1'b0, (k == nbits * 16)};
  endfunction

  task automatic test_reset();
    logic [10:0] bits;
    bits = {1'b0, 1'b1, 8'h00, 1'b0};
    rst = 1'b1;
    repeat (3) @(negedge ckht);
    vec_count++;
    if (obs_a !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL reset_state_a: got %b expected %b", obs_a, 4'b1000);
    end
    vec_count++;
    if (obs_b !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL reset_state_b: got %b expected %b", obs_b, 4'b1000);
    end
    vec_count++;
    if (obs_c !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL reset_state_c: got %b expected %b", obs_c, 4'b1000);
    end
    push_a(8'h00);
    #1;
    vec_count++;
    if (obs_a !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL no_pop_in_reset: got %b expected %b", obs_a, 4'b1000);
    end
    @(negedge ckht);
    rst = 1'b0;
    #1;
    vec_count++;
    if (obs_a !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL pop_after_reset: got %b expected %b", obs_a, 4'b1010);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge ckht);
      vec_count++;
      if (obs_a !== frame_exp(bits, 10, k)) begin
        miscompares++;
        $display("[TB] FAIL frame_00 k=%0d: got %b expected %b", k, obs_a, frame_exp(bits, 10, k));
      end
    end
    rst = 1'b1;
    #1;
    vec_count++;
    if (obs_a !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_frame: got %b expected %b", obs_a, 4'b1000);
    end
    @(negedge ckht);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ckht);
      vec_count++;
      if (obs_a !== 4'b1000) begin
        miscompares++;
        $display("[TB] FAIL idle_after_abort k=%0d: got %b expected %b", k, obs_a, 4'b1000);
      end
    end
    vec_count++;
    if (rd_a !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL pops_after_abort: got %0d expected %0d", rd_a, 1);
    end
  endtask

  task automatic test_single_8n1();
    logic [10:0] bits;
    bits = {1'b0, 1'b1, 8'h55, 1'b0};
    @(negedge ckht);
    push_a(8'h55);
    #1;
    vec_count++;
    if (obs_a !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL pop_55: got %b expected %b", obs_a, 4'b1010);
    end
    for (int k = 1; k <= 160; k++) begin
      @(negedge ckht);
      vec_count++;
      if (obs_a !== frame_exp(bits, 10, k)) begin
        miscompares++;
        $display("[TB] FAIL frame_55 k=%0d: got %b expected %b", k, obs_a, frame_exp(bits, 10, k));
      end
    end
    @(negedge ckht);
    vec_count++;
    if (obs_a !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL idle_after_55: got %b expected %b", obs_a, 4'b1000);
    end
  endtask

  task automatic test_parity_even();
    logic [10:0] bits;
    // 0xA3 has four ones, so the even parity bit is 0
    bits = {1'b1, 1'b0, 8'hA3, 1'b0};
    @(negedge ckht);
    push_b(8'hA3);
    #1;
    vec_count++;
    if (obs_b !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL pop_a3: got %b expected %b", obs_b, 4'b1010);
    end
    for (int k = 1; k <= 176; k++) begin
      @(negedge ckht);
      vec_count++;
      if (obs_b !== frame_exp(bits, 11, k)) begin
        miscompares++;
        $display("[TB] FAIL frame_a3 k=%0d: got %b expected %b", k, obs_b, frame_exp(bits, 11, k));
      end
    end
    @(negedge ckht);
    vec_count++;
    if (obs_b !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL idle_after_a3: got %b expected %b", obs_b, 4'b1000);
    end
  endtask

  task automatic test_two_stop();
    logic [10:0] bits;
    bits = {1'b1, 1'b1, 8'hFF, 1'b0};
    @(negedge ckht);
    push_c(8'hFF);
    #1;
    vec_count++;
    if (obs_c !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL pop_ff: got %b expected %b", obs_c, 4'b1010);
    end
    for (int k = 1; k <= 176; k++) begin
      @(negedge ckht);
      vec_count++;
      if (obs_c !== frame_exp(bits, 11, k)) begin
        miscompares++;
        $display("[TB] FAIL frame_ff k=%0d: got %b expected %b", k, obs_c, frame_exp(bits, 11, k));
      end
    end
    @(negedge ckht);
    vec_count++;
    if (obs_c !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL idle_after_ff: got %b expected %b", obs_c, 4'b1000);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] burst [3];
    logic [3:0]  gap_exp;
    burst[0] = {1'b0, 1'b1, 8'h01, 1'b0};
    burst[1] = {1'b0, 1'b1, 8'h02, 1'b0};
    burst[2] = {1'b0, 1'b1, 8'h03, 1'b0};
    @(negedge ckht);
    push_a(8'h01);
    push_a(8'h02);
    push_a(8'h03);
    #1;
    vec_count++;
    if (obs_a !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL pop_burst0: got %b expected %b", obs_a, 4'b1010);
    end
    for (int f = 0; f < 3; f++) begin
      for (int k = 1; k <= 160; k++) begin
        @(negedge ckht);
        vec_count++;
        if (obs_a !== frame_exp(burst[f], 10, k)) begin
          miscompares++;
          $display("[TB] FAIL burst%0d k=%0d: got %b expected %b", f, k, obs_a, frame_exp(burst[f], 10, k));
        end
      end
      gap_exp = (f < 2) ? 4'b1010 : 4'b1000;
      @(negedge ckht);
      vec_count++;
      if (obs_a !== gap_exp) begin
        miscompares++;
        $display("[TB] FAIL burst_gap%0d: got %b expected %b", f, obs_a, gap_exp);
      end
    end
    vec_count++;
    if (rd_a !== 32'd5) begin
      miscompares++;
      $display("[TB] FAIL burst_pops: got %0d expected %0d", rd_a, 5);
    end
  endtask

  task automatic test_empty_idle();
    logic [10:0] bits;
    bits = {1'b0, 1'b1, 8'h80, 1'b0};
    for (int k = 0; k < 1000; k++) begin
      @(negedge ckht);
      vec_count++;
      if (obs_a !== 4'b1000) begin
        miscompares++;
        $display("[TB] FAIL empty_idle k=%0d: got %b expected %b", k, obs_a, 4'b1000);
      end
    end
    push_a(8'h80);
    #1;
    vec_count++;
    if (obs_a !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL pop_80: got %b expected %b", obs_a, 4'b1010);
    end
    for (int k = 1; k <= 160; k++) begin
      @(negedge ckht);
      vec_count++;
      if (obs_a !== frame_exp(bits, 10, k)) begin
        miscompares++;
        $display("[TB] FAIL frame_80 k=%0d: got %b expected %b", k, obs_a, frame_exp(bits, 10, k));
      end
    end
    @(negedge ckht);
    vec_count++;
    if (obs_a !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL idle_after_80: got %b expected %b", obs_a, 4'b1000);
    end
    vec_count++;
    if (rd_a !== 32'd6) begin
      miscompares++;
      $display("[TB] FAIL total_pops: got %0d expected %0d", rd_a, 6);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] uart_tx_ctrl directed tests starting");
    test_reset();
    test_single_8n1();
    test_parity_even();
    test_two_stop();
    test_back_to_back();
    test_empty_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
